// File: rtl/code_entry_pkg.sv
`default_nettype none
// ============================================================================
// Package : code_entry_pkg
// Brief   : Shared definitions for the lock code-entry path: digit width and
//           the keypad transmitter state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package code_entry_pkg;

  // Bits per digit; the lock controller consumes the same {E1,E0} pair.
  localparam int DW = 2;

  // Transmitter state encoding.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_WAIT    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/enter_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : enter_sync_edge
// Brief   : Two-flop synchroniser for an asynchronous push-button level,
//           followed by a rising-edge detector producing a one-cycle pulse.
//           The pulse is high in the cycle after the second synchroniser
//           flop first sees the new level, so a consumer registers it on the
//           third clock edge after the button rises.
// Rev     : 1.0  initial release
// ============================================================================
module enter_sync_edge
  import code_entry_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // sync_sr[0..1] form the synchroniser; sync_sr[2] holds the previous level.
  logic [2:0] sync_sr;

  // Shift the raw level through the synchroniser and history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= 3'b000;
    end else begin
      sync_sr <= {sync_sr[1:0], din};
    end
  end

  assign pulse = sync_sr[1] & ~sync_sr[2];

endmodule
`default_nettype wire

// File: rtl/code_entry_tx.sv
`default_nettype none
// ============================================================================
// Module  : code_entry_tx
// Brief   : Keypad-side transmitter. Collects DIGITS digit codes, one per
//           Enter press, streams them to the lock over valid/ready, then
//           waits a bounded time for the verdict.
// Rev     : 1.0  initial release
// ============================================================================
module code_entry_tx
  import code_entry_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DW      = code_entry_pkg::DW,
  parameter int TIMEOUT = 15,
  localparam int CW     = $clog2(DIGITS + 1),
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          Clock,
  input  logic          Clear,
  input  logic          Enter,
  input  logic          Cancel,
  input  logic [DW-1:0] Digit,
  output logic [DW-1:0] E_Data,
  output logic          E_Valid,
  input  logic          E_Ready,
  input  logic          Result_Valid,
  input  logic          Result_Ok,
  output logic [CW-1:0] Count,
  output logic          Busy,
  output logic          Pass_LED,
  output logic          Err
);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic [7:0]    timer;
  logic          pass_led;
  logic          err;
  logic          enter_p;
  logic          cap_en;
  logic [CW-1:0] cap_slot;
  logic [DW-1:0] digit_buf [DIGITS];

  enter_sync_edge u_enter_sync (
    .clk   (Clock),
    .rst_n (Clear),
    .din   (Enter),
    .pulse (enter_p)
  );

  // Decide whether this cycle captures a digit and into which slot.
  always_comb begin
    cap_en   = 1'b0;
    cap_slot = '0;
    if (state == S_IDLE && enter_p) begin
      cap_en = 1'b1;
    end else if (state == S_COLLECT && enter_p && !Cancel && count < CW'(DIGITS)) begin
      cap_en   = 1'b1;
      cap_slot = count;
    end
  end

  // One register per digit slot, written only on its own capture.
  for (genvar g = 0; g < DIGITS; g++) begin : g_buf
    always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
        digit_buf[g] <= '0;
      end else if (cap_en && cap_slot == CW'(g)) begin
        digit_buf[g] <= Digit;
      end
    end
  end

  // Main FSM: collect, send, then await the verdict or time out.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= S_IDLE;
      idx      <= '0;
      count    <= '0;
      timer    <= 8'd0;
      pass_led <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enter_p) begin
            count    <= CW'(1);
            err      <= 1'b0;
            pass_led <= 1'b0;
            idx      <= '0;
            state    <= (DIGITS == 1) ? S_SEND : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (Cancel) begin
            count <= '0;
            state <= S_IDLE;
          end else if (enter_p && count < CW'(DIGITS)) begin
            count <= count + CW'(1);
            if (count == CW'(DIGITS - 1)) begin
              idx   <= '0;
              state <= S_SEND;
            end
          end
        end
        S_SEND: begin
          // A started word always completes: Cancel and Enter are ignored here.
          if (E_Ready) begin
            if (idx == IW'(DIGITS - 1)) begin
              idx   <= '0;
              timer <= 8'd0;
              state <= S_WAIT;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_WAIT: begin
          // Verdict beats timeout, which beats Cancel.
          if (Result_Valid) begin
            pass_led <= Result_Ok;
            count    <= '0;
            state    <= S_IDLE;
          end else if (timer == 8'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            pass_led <= 1'b0;
            count    <= '0;
            state    <= S_IDLE;
          end else if (Cancel) begin
            count <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state so reset removes E_Valid at once.
  assign E_Valid  = (state == S_SEND);
  assign E_Data   = E_Valid ? digit_buf[idx] : '0;
  assign Busy     = (state == S_SEND) || (state == S_WAIT);
  assign Count    = count;
  assign Pass_LED = pass_led;
  assign Err      = err;

endmodule
`default_nettype wire
